// File: rtl/ex_mem_latch_pkg.sv
// Shared memory-access encodings and control bundle for the EX/MEM boundary.
// mem_size values are common to the decoder, this latch and the MEM stage.
package ex_mem_latch_pkg;

  localparam int DATA_W = 32;

  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

  localparam int BE_W = be_width(DATA_W);

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'b00,
    MEM_SIZE_HALF = 2'b01,
    MEM_SIZE_WORD = 2'b10
  } mem_size_e;

  localparam logic [BE_W-1:0] BE_ALL  = '1;
  localparam logic [BE_W-1:0] BE_NONE = '0;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_unsigned;
  } ctrl_t;

endpackage

// File: rtl/ex_mem_latch_if.sv
// EX-stage inputs and registered EX/MEM outputs of the pipeline latch.
// slave = the latch itself; master = the EX stage / environment driving it.
interface ex_mem_latch_if #(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  localparam int BE_WIDTH = DATA_BUS_WIDTH / 8;

  logic                      enable;
  logic                      flush;
  logic [DATA_BUS_WIDTH-1:0] alu_result;
  logic [DATA_BUS_WIDTH-1:0] rt_data;
  logic [REG_ADDR_WIDTH-1:0] wr_reg;
  logic                      reg_write;
  logic                      mem_to_reg;
  logic                      mem_read;
  logic                      mem_write;
  logic [1:0]                mem_size;
  logic                      mem_unsigned;
  logic                      halt;

  logic [DATA_BUS_WIDTH-1:0] out_alu_result;
  logic [DATA_BUS_WIDTH-1:0] out_store_data;
  logic [BE_WIDTH-1:0]       out_byte_en;
  logic [REG_ADDR_WIDTH-1:0] out_wr_reg;
  logic                      out_reg_write;
  logic                      out_mem_to_reg;
  logic                      out_mem_read;
  logic                      out_mem_write;
  logic                      out_mem_unsigned;
  logic [1:0]                out_mem_size;
  logic                      out_misaligned;
  logic                      out_halted;

  modport slave (
    input  enable, flush, alu_result, rt_data, wr_reg, reg_write, mem_to_reg,
           mem_read, mem_write, mem_size, mem_unsigned, halt,
    output out_alu_result, out_store_data, out_byte_en, out_wr_reg, out_reg_write,
           out_mem_to_reg, out_mem_read, out_mem_write, out_mem_unsigned,
           out_mem_size, out_misaligned, out_halted
  );

  modport master (
    output enable, flush, alu_result, rt_data, wr_reg, reg_write, mem_to_reg,
           mem_read, mem_write, mem_size, mem_unsigned, halt,
    input  out_alu_result, out_store_data, out_byte_en, out_wr_reg, out_reg_write,
           out_mem_to_reg, out_mem_read, out_mem_write, out_mem_unsigned,
           out_mem_size, out_misaligned, out_halted
  );
endinterface

// File: rtl/ex_mem_latch_store_align.sv
// Store lane replication, byte strobes and alignment check; purely combinational.
// Strobes are zero for non-stores and for any misaligned access.
module ex_mem_latch_store_align
  import ex_mem_latch_pkg::*;
(
  input  logic [1:0]        mem_size,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] store_data,
  output logic [BE_W-1:0]   byte_en,
  output logic              misaligned
);
  logic [BE_W-1:0] lane_en;
  logic            align_bad;

  always_comb begin
    store_data = rt_data;
    lane_en    = BE_ALL;
    align_bad  = 1'b0;
    case (mem_size)
      MEM_SIZE_BYTE: begin
        store_data = {4{rt_data[7:0]}};
        lane_en    = {{(BE_W-1){1'b0}}, 1'b1} << addr;
      end
      MEM_SIZE_HALF: begin
        store_data = {2{rt_data[15:0]}};
        lane_en    = addr[1] ? 4'b1100 : 4'b0011;
        align_bad  = addr[0];
      end
      // reserved encoding behaves as a word access
      default: begin
        align_bad  = (addr != 2'b00);
      end
    endcase
  end

  assign misaligned = (mem_read | mem_write) & align_bad;
  assign byte_en    = (mem_write && !misaligned) ? lane_en : BE_NONE;

endmodule

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with store alignment, flush bubbles and sticky halt; 1-cycle latency.
// enable=0 stalls (all state held); flush wins over stall; once halted every advance is a bubble.
module ex_mem_latch
  import ex_mem_latch_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int BE_WIDTH       = be_width(DATA_BUS_WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  ex_mem_latch_if.slave bus
);
  logic [DATA_BUS_WIDTH-1:0] sa_data;
  logic [BE_WIDTH-1:0]       sa_be;
  logic                      sa_mis;
  ctrl_t                     ctrl_in;

  logic [DATA_BUS_WIDTH-1:0] alu_q;
  logic [DATA_BUS_WIDTH-1:0] data_q;
  logic [BE_WIDTH-1:0]       be_q;
  logic [REG_ADDR_WIDTH-1:0] wr_reg_q;
  ctrl_t                     ctrl_q;
  logic                      mis_q;
  logic                      halted_q;

  ex_mem_latch_store_align u_store_align (
    .mem_size   (bus.mem_size),
    .addr       (bus.alu_result[1:0]),
    .rt_data    (bus.rt_data),
    .mem_read   (bus.mem_read),
    .mem_write  (bus.mem_write),
    .store_data (sa_data),
    .byte_en    (sa_be),
    .misaligned (sa_mis)
  );

  // A misaligned access keeps its address/destination visible but must not touch memory or the RF.
  assign ctrl_in = '{
    reg_write:    bus.reg_write & ~sa_mis,
    mem_to_reg:   bus.mem_to_reg,
    mem_read:     bus.mem_read  & ~sa_mis,
    mem_write:    bus.mem_write & ~sa_mis,
    mem_size:     bus.mem_size,
    mem_unsigned: bus.mem_unsigned
  };

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q    <= '0;
      data_q   <= '0;
      be_q     <= '0;
      wr_reg_q <= '0;
      ctrl_q   <= '0;
      mis_q    <= 1'b0;
      halted_q <= 1'b0;
    end else if (bus.flush) begin
      alu_q    <= '0;
      data_q   <= '0;
      be_q     <= '0;
      wr_reg_q <= '0;
      ctrl_q   <= '0;
      mis_q    <= 1'b0;
    end else if (!bus.enable) begin
      alu_q    <= alu_q;
    end else if (halted_q || bus.halt) begin
      // the HALT instruction itself also retires as a bubble
      alu_q    <= '0;
      data_q   <= '0;
      be_q     <= '0;
      wr_reg_q <= '0;
      ctrl_q   <= '0;
      mis_q    <= 1'b0;
      halted_q <= 1'b1;
    end else begin
      alu_q    <= bus.alu_result;
      data_q   <= sa_data;
      be_q     <= sa_be;
      wr_reg_q <= bus.wr_reg;
      ctrl_q   <= ctrl_in;
      mis_q    <= sa_mis;
    end
  end

  assign bus.out_alu_result   = alu_q;
  assign bus.out_store_data   = data_q;
  assign bus.out_byte_en      = be_q;
  assign bus.out_wr_reg       = wr_reg_q;
  assign bus.out_reg_write    = ctrl_q.reg_write;
  assign bus.out_mem_to_reg   = ctrl_q.mem_to_reg;
  assign bus.out_mem_read     = ctrl_q.mem_read;
  assign bus.out_mem_write    = ctrl_q.mem_write;
  assign bus.out_mem_unsigned = ctrl_q.mem_unsigned;
  assign bus.out_mem_size     = ctrl_q.mem_size;
  assign bus.out_misaligned   = mis_q;
  assign bus.out_halted       = halted_q;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Randomized and directed bench for ex_mem_latch against a behavioural edge model.
module tb_ex_mem_latch;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ex_mem_latch_if #(.DATA_BUS_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  ex_mem_latch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // expected architectural state of the latch
  logic [31:0] e_alu, e_sd;
  logic [3:0]  e_be;
  logic [4:0]  e_wr;
  logic        e_rw, e_m2r, e_mr, e_mw, e_mu, e_mis, e_halted;
  logic [1:0]  e_msz;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_bubble();
    e_alu = 0; e_sd = 0; e_be = 0; e_wr = 0; e_rw = 0; e_m2r = 0;
    e_mr = 0; e_mw = 0; e_mu = 0; e_msz = 0; e_mis = 0;
  endtask

  task automatic model_edge();
    int unsigned a;
    logic [31:0] sd;
    int unsigned be;
    bit bad, mis;
    if (reset) begin
      model_bubble();
      e_halted = 0;
    end else if (bus.flush) begin
      model_bubble();
    end else if (!bus.enable) begin
      // stalled: nothing moves
    end else if (e_halted || bus.halt) begin
      model_bubble();
      e_halted = 1;
    end else begin
      a = bus.alu_result % 4;
      if (bus.mem_size == 2'd0) begin
        sd = bus.rt_data[7:0] * 32'h0101_0101;
        be = 2 ** a;
        bad = 0;
      end else if (bus.mem_size == 2'd1) begin
        sd = bus.rt_data[15:0] * 32'h0001_0001;
        be = (a >= 2) ? 12 : 3;
        bad = (a % 2) != 0;
      end else begin
        sd = bus.rt_data;
        be = 15;
        bad = (a != 0);
      end
      mis   = (bus.mem_read || bus.mem_write) && bad;
      e_alu = bus.alu_result;
      e_sd  = sd;
      e_be  = (bus.mem_write && !mis) ? 4'(be) : 4'd0;
      e_wr  = bus.wr_reg;
      e_rw  = bus.reg_write && !mis;
      e_mr  = bus.mem_read  && !mis;
      e_mw  = bus.mem_write && !mis;
      e_m2r = bus.mem_to_reg;
      e_mu  = bus.mem_unsigned;
      e_msz = bus.mem_size;
      e_mis = mis;
    end
  endtask

  task automatic compare_all();
    check_eq("alu_result", bus.out_alu_result,   e_alu);
    check_eq("store_data", bus.out_store_data,   e_sd);
    check_eq("byte_en",    32'(bus.out_byte_en), 32'(e_be));
    check_eq("wr_reg",     32'(bus.out_wr_reg),  32'(e_wr));
    check_eq("reg_write",  32'(bus.out_reg_write),    32'(e_rw));
    check_eq("mem_to_reg", 32'(bus.out_mem_to_reg),   32'(e_m2r));
    check_eq("mem_read",   32'(bus.out_mem_read),     32'(e_mr));
    check_eq("mem_write",  32'(bus.out_mem_write),    32'(e_mw));
    check_eq("mem_unsign", 32'(bus.out_mem_unsigned), 32'(e_mu));
    check_eq("mem_size",   32'(bus.out_mem_size),     32'(e_msz));
    check_eq("misaligned", 32'(bus.out_misaligned),   32'(e_mis));
    check_eq("halted",     32'(bus.out_halted),       32'(e_halted));
  endtask

  // inputs are set #1 after an edge; the model sees the same values the DUT samples
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    reset = 0;
    bus.enable = 1; bus.flush = 0; bus.halt = 0;
    bus.alu_result = 0; bus.rt_data = 0; bus.wr_reg = 0;
    bus.reg_write = 0; bus.mem_to_reg = 0; bus.mem_read = 0; bus.mem_write = 0;
    bus.mem_size = 0; bus.mem_unsigned = 0;
  endtask

  task automatic random_payload();
    bus.alu_result   = $urandom;
    bus.rt_data      = $urandom;
    bus.wr_reg       = 5'($urandom);
    bus.reg_write    = 1'($urandom);
    bus.mem_to_reg   = 1'($urandom);
    bus.mem_read     = 1'($urandom);
    bus.mem_write    = 1'($urandom);
    bus.mem_size     = 2'($urandom_range(0, 3));
    bus.mem_unsigned = 1'($urandom);
  endtask

  initial begin
    e_halted = 0;
    model_bubble();
    idle_inputs();

    // reset with enable high and junk on every input
    random_payload();
    reset = 1; bus.halt = 1;
    cycle();
    check_eq("rst_halted", 32'(bus.out_halted), 32'd0);

    // store byte at ...13
    idle_inputs();
    bus.alu_result = 32'h13; bus.rt_data = 32'hAABBCCDD; bus.mem_write = 1; bus.mem_size = 2'b00;
    cycle();
    check_eq("sb_data", bus.out_store_data, 32'hDDDDDDDD);
    check_eq("sb_be",   32'(bus.out_byte_en), 32'h8);

    // store half at ...02
    bus.alu_result = 32'h102; bus.rt_data = 32'h1234ABCD; bus.mem_size = 2'b01;
    cycle();
    check_eq("sh_data", bus.out_store_data, 32'hABCDABCD);
    check_eq("sh_be",   32'(bus.out_byte_en), 32'hC);

    // misaligned load word at ...06
    idle_inputs();
    bus.alu_result = 32'h106; bus.mem_read = 1; bus.reg_write = 1; bus.mem_size = 2'b10; bus.wr_reg = 5'd9;
    cycle();
    check_eq("lw_mis", 32'(bus.out_misaligned), 32'd1);
    check_eq("lw_rw",  32'(bus.out_reg_write),  32'd0);
    check_eq("lw_addr", bus.out_alu_result, 32'h106);

    // capture, stall three cycles with changing inputs, then flush during stall
    idle_inputs();
    bus.alu_result = 32'h5; bus.wr_reg = 5'd3; bus.reg_write = 1;
    cycle();
    for (int i = 0; i < 3; i++) begin
      random_payload();
      bus.enable = 0;
      cycle();
    end
    check_eq("stall_alu", bus.out_alu_result, 32'h5);
    check_eq("stall_wr",  32'(bus.out_wr_reg), 32'd3);
    bus.flush = 1; bus.enable = 0;
    cycle();
    check_eq("flush_rw", 32'(bus.out_reg_write), 32'd0);

    // halt, then two valid instructions become bubbles, then reset
    idle_inputs();
    bus.halt = 1; bus.alu_result = 32'h40; bus.mem_write = 1; bus.mem_size = 2'b10;
    cycle();
    check_eq("halt_set", 32'(bus.out_halted), 32'd1);
    bus.halt = 0;
    for (int i = 0; i < 2; i++) begin
      random_payload();
      bus.reg_write = 1;
      cycle();
    end
    check_eq("halt_bub", 32'(bus.out_reg_write), 32'd0);
    reset = 1;
    cycle();
    check_eq("halt_clr", 32'(bus.out_halted), 32'd0);

    // halt with flush: flush wins; halt with stall: nothing changes
    idle_inputs();
    bus.halt = 1; bus.flush = 1;
    cycle();
    bus.flush = 0; bus.enable = 0;
    cycle();
    check_eq("halt_prio", 32'(bus.out_halted), 32'd0);

    // reserved size behaves as word: misaligned store at ...01
    idle_inputs();
    bus.alu_result = 32'h201; bus.mem_write = 1; bus.mem_size = 2'b11;
    cycle();
    check_eq("rsv_mis", 32'(bus.out_misaligned), 32'd1);
    check_eq("rsv_be",  32'(bus.out_byte_en), 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      random_payload();
      reset      = ($urandom_range(0, 29) == 0);
      bus.flush  = ($urandom_range(0, 7) == 0);
      bus.enable = ($urandom_range(0, 5) != 0);
      bus.halt   = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
